// File: rtl/game_level_sequencer.sv
// Game flow controller: idle, per-level pre-game/play, randomize, pause, win and lose phases.
// One level counter stands in for per-level states. Background, freeze and HUD outputs decode from the state.
module game_level_sequencer #(
  parameter int NUM_LEVELS  = 3,
  parameter int RAND_LEVEL  = 3,
  parameter int START_LIVES = 3,
  parameter int MAX_LIVES   = 5,
  parameter int LVL_W       = $clog2(NUM_LEVELS + 1),
  parameter int LIFE_W      = $clog2(MAX_LIVES + 1)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  input  logic              risingSpace,
  input  logic              brakeSpace,
  input  logic              pauseKey,
  input  logic              noBrick,
  input  logic              hitbottom,
  input  logic              bonusLife,
  input  logic [3:0]        numKey,
  output logic              preState,
  output logic              random,
  output logic              paused,
  output logic [2:0]        bgState,
  output logic [LIFE_W-1:0] life,
  output logic [LVL_W-1:0]  lvl,
  output logic              levelStart
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_RAND  = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  localparam logic [LIFE_W-1:0] START_L = LIFE_W'(START_LIVES);
  localparam logic [LIFE_W-1:0] MAX_L   = LIFE_W'(MAX_LIVES);
  localparam logic [LVL_W-1:0]  LAST_L  = LVL_W'(NUM_LEVELS);
  localparam logic [LVL_W-1:0]  FIRST_L = LVL_W'(1);

  state_t              state_r;
  logic [LVL_W-1:0]    cnt_r;
  logic [LIFE_W-1:0]   life_r;
  logic                levelStart_r;
  logic                jump_s;
  logic                bonus_inc_s;
  logic [LVL_W-1:0]    key_lvl_s;
  logic [LIFE_W-1:0]   hit_life_s;
  logic [LIFE_W-1:0]   bonus_life_s;

  // The randomize phase is the entry point only for the configured level
  function automatic state_t entry_state(input logic [LVL_W-1:0] l);
    if ((RAND_LEVEL != 0) && (int'(l) == RAND_LEVEL)) begin
      return S_RAND;
    end else begin
      return S_PRE;
    end
  endfunction

  assign key_lvl_s    = LVL_W'(numKey);
  assign jump_s       = (state_r != S_PAUSE) && (numKey != 4'd0) &&
                        ({1'b0, numKey} <= 5'(NUM_LEVELS)) &&
                        ({1'b0, numKey} != 5'(lvl));
  assign bonus_inc_s  = bonusLife && (life_r < MAX_L);
  assign hit_life_s   = life_r - LIFE_W'(1) + (bonus_inc_s ? LIFE_W'(1) : LIFE_W'(0));
  assign bonus_life_s = bonus_inc_s ? (life_r + LIFE_W'(1)) : life_r;

  // Game state, level counter, lives and the first-PLAY-cycle pulse
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      life_r       <= START_L;
      levelStart_r <= 1'b0;
    end else begin
      levelStart_r <= 1'b0;
      if (jump_s) begin
        cnt_r   <= key_lvl_s;
        state_r <= entry_state(key_lvl_s);
        if ((state_r == S_IDLE) || (state_r == S_WIN) || (state_r == S_LOSE)) begin
          life_r <= START_L;
        end
      end else begin
        case (state_r)
          S_IDLE: if (start) begin
            cnt_r   <= FIRST_L;
            state_r <= entry_state(FIRST_L);
          end
          S_PRE: if (risingSpace) begin
            state_r      <= S_PLAY;
            levelStart_r <= 1'b1;
          end
          S_RAND: if (brakeSpace) begin
            state_r <= S_PRE;
          end
          S_PLAY: begin
            if (pauseKey) begin
              state_r <= S_PAUSE;
            end else if (hitbottom) begin
              life_r  <= hit_life_s;
              state_r <= (hit_life_s == '0) ? S_LOSE : S_PRE;
            end else if (noBrick) begin
              if (cnt_r == LAST_L) begin
                state_r <= S_WIN;
              end else begin
                cnt_r   <= cnt_r + LVL_W'(1);
                state_r <= entry_state(cnt_r + LVL_W'(1));
              end
            end else begin
              life_r <= bonus_life_s;
            end
          end
          S_PAUSE: if (pauseKey) begin
            state_r <= S_PLAY;
          end
          S_WIN, S_LOSE: if (start) begin
            life_r  <= START_L;
            cnt_r   <= FIRST_L;
            state_r <= entry_state(FIRST_L);
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  // Moore decode of the display and freeze outputs
  always_comb begin
    bgState  = 3'd1;
    preState = 1'b1;
    random   = 1'b0;
    paused   = 1'b0;
    lvl      = '0;
    case (state_r)
      S_IDLE:  bgState = 3'd1;
      S_PRE:   begin bgState = 3'd0; lvl = cnt_r; end
      S_RAND:  begin bgState = 3'd2; random = 1'b1; lvl = cnt_r; end
      S_PLAY:  begin bgState = 3'd0; preState = 1'b0; lvl = cnt_r; end
      S_PAUSE: begin bgState = 3'd5; paused = 1'b1; lvl = cnt_r; end
      S_WIN:   bgState = 3'd3;
      S_LOSE:  bgState = 3'd4;
      default: bgState = 3'd1;
    endcase
  end

  assign life       = life_r;
  assign levelStart = levelStart_r;

endmodule

// File: doc/game_level_sequencer.md
# game_level_sequencer

Parametrised top-level game flow controller: sequences idle, per-level pre-game/play, randomize, pause, win and lose phases. Level count, life budget and the randomized level are parameters. A level counter replaces per-level states. Outputs drive background select, brick randomizer enable, ball/paddle freeze and HUD life/level display.

## Interface
- NUM_LEVELS, 3, number of playable levels, 1..15
- RAND_LEVEL, 3, level index entered through the randomize phase; 0 = none
- START_LIVES, 3, lives at game start/restart, 1..MAX_LIVES
- MAX_LIVES, 5, bonus-life saturation value
- LVL_W, $clog2(NUM_LEVELS+1), derived
- LIFE_W, $clog2(MAX_LIVES+1), derived

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- start  in  1  start/restart request (level)
- risingSpace  in  1  one-cycle space-press pulse
- brakeSpace  in  1  one-cycle space-release pulse
- pauseKey  in  1  one-cycle pause-toggle pulse
- noBrick  in  1  all bricks cleared
- hitbottom  in  1  one-cycle ball-lost pulse
- bonusLife  in  1  one-cycle extra-life pulse
- numKey  in  4  keypad digit, level-held
- preState  out  1  play objects frozen
- random  out  1  brick randomizer enable
- paused  out  1  pause active
- bgState  out  3  background select
- life  out  LIFE_W  remaining lives
- lvl  out  LVL_W  current level, 0 outside levels
- levelStart  out  1  one-cycle pulse on entering PLAY

## Operation
- Registered: state, level counter, life, levelStart. All other outputs Moore-decoded from state.
- States: IDLE, PRE, RAND, PLAY, PAUSE, WIN, LOSE.
- Decode:
  - IDLE: bgState=1, preState=1, lvl=0.
  - PRE: bgState=0, preState=1.
  - RAND: bgState=2, preState=1, random=1.
  - PLAY: bgState=0, preState=0.
  - PAUSE: bgState=5, preState=1, paused=1.
  - WIN: bgState=3, preState=1, lvl=0.
  - LOSE: bgState=4, preState=1, lvl=0.
- In PRE/RAND/PLAY/PAUSE, lvl = level counter.
- Enter level L: counter := L. If L==RAND_LEVEL, go RAND; else go PRE.
- IDLE: start enters level 1.
- PRE: risingSpace goes to PLAY; levelStart pulses.
- RAND: brakeSpace goes to PRE.
- PLAY, in priority order:
  1. pauseKey goes to PAUSE.
  2. hitbottom: life' = life − 1 + (bonusLife && life<MAX_LIVES). If life' == 0, go LOSE; else go to PRE of the same level. RAND is not re-entered.
  3. noBrick: if counter==NUM_LEVELS, go WIN; else enter level counter+1.
  4. bonusLife alone: life := min(life+1, MAX_LIVES).
- PAUSE: pauseKey returns to PLAY. All other inputs ignored, including numKey.
- WIN/LOSE: start enters level 1 with life := START_LIVES.
- Level jump:
  - Trigger: numKey in 1..NUM_LEVELS and numKey ≠ lvl, in any state except PAUSE.
  - Action: enter level numKey.
  - Priority: overrides every other transition that cycle.
  - Life: from WIN/LOSE/IDLE, life := START_LIVES; otherwise life unchanged.
  - numKey 0 or >NUM_LEVELS is ignored.
  - A held key does not retrigger, because lvl then equals numKey.

## Timing
- Reset (async, immediate): state=IDLE, counter=0, life=START_LIVES, levelStart=0. Outputs: bgState=1, preState=1, random=0, paused=0, lvl=0.
- All transitions take effect at the clk edge after the sampled input; decoded outputs change in the same cycle as the state.
- levelStart is high for exactly the first PLAY cycle. It is not asserted on PAUSE→PLAY.
- life never underflows below 0 and never exceeds MAX_LIVES.
- hitbottom + bonusLife in the same cycle with life==1: life stays 1, go PRE (no LOSE).
- hitbottom + noBrick in the same cycle: hitbottom wins.
- Reset deasserted mid-level always restarts at IDLE; nothing is retained.
- RAND_LEVEL=0: RAND is unreachable and random stays 0.

## Test plan
- Reset, start=1, then risingSpace → PRE lvl=1 preState=1. Next cycle PLAY preState=0, levelStart high for one cycle, life=3.
- Level 1 PLAY, noBrick → PRE lvl=2. Level 2, noBrick → RAND lvl=3, random=1, bgState=2. brakeSpace → PRE. risingSpace → PLAY. noBrick → WIN bgState=3, lvl=0.
- life=3, three hitbottom pulses (with risingSpace between them) → life 2, 1, then LOSE bgState=4, life=0. start → PRE lvl=1, life=3.
- life=1, hitbottom+bonusLife in the same cycle → PRE, life=1. Five bonusLife pulses in PLAY → life saturates at 5.
- PLAY, pauseKey → PAUSE paused=1, bgState=5. hitbottom, noBrick and numKey=2 are all ignored. pauseKey → PLAY, levelStart=0.
- In PLAY lvl=1, hold numKey=2 for 10 cycles → single jump to PRE lvl=2, life unchanged. numKey=7 (NUM_LEVELS=3) → no effect. Assert resetN low mid-PLAY → IDLE immediately.
